hqm_jg_clk_mon: RTL and testbench

Formal/simulation clock monitor that observes a divided clock produced from `reference_clk` and checks it against an expected half-period. It samples the observed clock, measures the number of reference cycles between edges, locks after a programmable run of matching half-periods, and flags mismatches and stalls with sticky error bits. It sits beside the clock generator in formal harnesses and acts as the receiving/checking end of the generated clock, so JasperGold properties can be written against `locked` and `err`.

---
 rtl/hqm_jg_clk_mon.sv | 133 +++++++++++++
 tb/tb_hqm_jg_clk_mon.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hqm_jg_clk_mon.sv
// Clock monitor: measures half-periods of a sampled clock against an expected value,
// locks after a run of matches, then flags mismatches and stalls with sticky bits.
`timescale 1ns/1ps
module hqm_jg_clk_mon #(
  parameter int WIDTH      = 4,
  parameter int LOCK_EDGES = 4
) (
  input  logic             reference_clk,
  input  logic             reference_rst_n,
  input  logic             enable,
  input  logic             clk_obs,
  input  logic [WIDTH-1:0] exp_freq,
  output logic             locked,
  output logic             err,
  output logic             err_stall,
  output logic [WIDTH:0]   half_period
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    ERR    = 2'd3
  } state_t;

  localparam logic [4:0]       LOCK_TGT = 5'(LOCK_EDGES);
  localparam logic [WIDTH+1:0] RUN_ONE  = {{(WIDTH+1){1'b0}}, 1'b1};

  state_t           r_state;
  logic             r_clk_obs_f;
  logic             r_first;
  logic             r_locked;
  logic             r_err;
  logic             r_err_stall;
  logic [WIDTH+1:0] r_run;
  logic [3:0]       r_match_cnt;
  logic [WIDTH:0]   r_half_period;

  logic             w_edge;
  logic [WIDTH:0]   w_exp_eff;
  logic [WIDTH+1:0] w_stall_lim;
  logic             w_meas_ok;
  logic [WIDTH:0]   w_meas_sat;
  logic             w_run_max;
  logic [4:0]       w_match_inc;

  // A zero expected value encodes the full 2^WIDTH half-period.
  assign w_exp_eff   = (exp_freq == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, exp_freq};
  assign w_stall_lim = {w_exp_eff, 1'b0};
  assign w_edge      = (clk_obs != r_clk_obs_f) && (r_state != IDLE);
  assign w_meas_ok   = (r_run == {1'b0, w_exp_eff});
  assign w_meas_sat  = r_run[WIDTH+1] ? {(WIDTH+1){1'b1}} : r_run[WIDTH:0];
  assign w_run_max   = &r_run;
  assign w_match_inc = {1'b0, r_match_cnt} + 5'd1;

  always_ff @(posedge reference_clk or negedge reference_rst_n) begin
    if (!reference_rst_n) begin
      r_state       <= IDLE;
      r_clk_obs_f   <= 1'b0;
      r_first       <= 1'b0;
      r_locked      <= 1'b0;
      r_err         <= 1'b0;
      r_err_stall   <= 1'b0;
      r_run         <= '0;
      r_match_cnt   <= '0;
      r_half_period <= '0;
    end else begin
      r_clk_obs_f <= clk_obs;
      if (r_state == IDLE) begin
        r_run         <= '0;
        r_match_cnt   <= '0;
        r_half_period <= '0;
        r_locked      <= 1'b0;
        if (enable) begin
          r_state <= ACQ;
          r_first <= 1'b1;
        end
      end else begin
        // Measurement path runs in every active state, including ERR.
        if (w_edge) begin
          r_run         <= RUN_ONE;
          r_half_period <= w_meas_sat;
        end else if (!w_run_max) begin
          r_run <= r_run + RUN_ONE;
        end

        if (!enable) begin
          r_state  <= IDLE;
          r_locked <= 1'b0;
        end else begin
          case (r_state)
            ACQ: begin
              if (w_edge) begin
                if (r_first) begin
                  r_first <= 1'b0;
                end else if (w_meas_ok) begin
                  r_match_cnt <= w_match_inc[3:0];
                  if (w_match_inc == LOCK_TGT) begin
                    r_state  <= LOCKED;
                    r_locked <= 1'b1;
                  end
                end else begin
                  r_match_cnt <= '0;
                end
              end
            end
            LOCKED: begin
              // An edge outranks a simultaneous stall.
              if (w_edge) begin
                if (!w_meas_ok) begin
                  r_err    <= 1'b1;
                  r_state  <= ERR;
                  r_locked <= 1'b0;
                end
              end else if (r_run == w_stall_lim) begin
                r_err_stall <= 1'b1;
                r_state     <= ERR;
                r_locked    <= 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign locked      = r_locked;
  assign err         = r_err;
  assign err_stall   = r_err_stall;
  assign half_period = r_half_period;

endmodule

// File: tb/tb_hqm_jg_clk_mon.sv
// Bench for hqm_jg_clk_mon: directed scenarios plus random half-period streams,
// checked every cycle against a timestamp-based reference model.
`timescale 1ns/1ps
module tb_hqm_jg_clk_mon;
  localparam int W  = 4;
  localparam int LE = 4;
  localparam int M_IDLE = 0, M_ACQ = 1, M_LOCKED = 2, M_ERR = 3;

  logic         reference_clk;
  logic         reference_rst_n;
  logic         enable;
  logic         clk_obs;
  logic [W-1:0] exp_freq;
  logic         locked;
  logic         err;
  logic         err_stall;
  logic [W:0]   half_period;

  int total = 0;
  int bad   = 0;

  // Reference model: time-since-last-edge instead of a counter.
  int m_mode, m_ref, m_cyc, m_hp, m_matches;
  bit m_prev, m_first, m_err, m_stall;

  logic obs_lvl;
  logic en_lvl;

  hqm_jg_clk_mon #(.WIDTH(W), .LOCK_EDGES(LE)) dut (
    .reference_clk   (reference_clk),
    .reference_rst_n (reference_rst_n),
    .enable          (enable),
    .clk_obs         (clk_obs),
    .exp_freq        (exp_freq),
    .locked          (locked),
    .err             (err),
    .err_stall       (err_stall),
    .half_period     (half_period)
  );

  initial reference_clk = 1'b0;
  always #5 reference_clk = ~reference_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_mode = M_IDLE; m_hp = 0; m_matches = 0;
    m_prev = 1'b0; m_first = 1'b0; m_err = 1'b0; m_stall = 1'b0;
  endtask

  task automatic m_step();
    int  e, meas;
    bit  edge_s;
    e = (exp_freq == '0) ? (1 << W) : int'(exp_freq);
    meas = m_cyc - m_ref;
    if (meas > (1 << (W + 2)) - 1) meas = (1 << (W + 2)) - 1;
    edge_s = (m_mode != M_IDLE) && (clk_obs != m_prev);
    if (m_mode == M_IDLE) begin
      m_hp = 0; m_matches = 0;
      if (enable) begin
        m_mode = M_ACQ; m_first = 1'b1; m_ref = m_cyc + 1;
      end
    end else begin
      if (edge_s) m_hp = (meas > (1 << (W + 1)) - 1) ? (1 << (W + 1)) - 1 : meas;
      if (!enable) begin
        m_mode = M_IDLE;
      end else if (m_mode == M_ACQ && edge_s) begin
        if (m_first) m_first = 1'b0;
        else if (meas == e) begin
          m_matches++;
          if (m_matches == LE) m_mode = M_LOCKED;
        end else m_matches = 0;
      end else if (m_mode == M_LOCKED) begin
        if (edge_s && meas != e) begin
          m_err = 1'b1; m_mode = M_ERR;
        end else if (!edge_s && meas == 2 * e) begin
          m_stall = 1'b1; m_mode = M_ERR;
        end
      end
      if (edge_s) m_ref = m_cyc;
    end
    m_prev = clk_obs;
    m_cyc++;
  endtask

  task automatic cyc(input logic obs, input logic en);
    @(negedge reference_clk);
    clk_obs = obs;
    enable  = en;
    @(posedge reference_clk);
    m_step();
    #1;
    chk("locked", {31'd0, locked}, (m_mode == M_LOCKED) ? 1 : 0);
    chk("err", {31'd0, err}, {31'd0, m_err});
    chk("err_stall", {31'd0, err_stall}, {31'd0, m_stall});
    chk("half_period", {27'd0, half_period}, m_hp);
  endtask

  task automatic half(input int h);
    obs_lvl = ~obs_lvl;
    repeat (h) cyc(obs_lvl, en_lvl);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    #2;
    reference_rst_n = 1'b0;
    enable  = 1'b0;
    clk_obs = 1'b0;
    obs_lvl = 1'b0;
    #1;
    m_reset();
    chk("rst_locked", {31'd0, locked}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_stall", {31'd0, err_stall}, 0);
    chk("rst_hp", {27'd0, half_period}, 0);
    @(posedge reference_clk);
    #1;
    reference_rst_n = 1'b1;
  endtask

  initial begin
    int hs [8];
    int e, r, h;
    reference_rst_n = 1'b0;
    enable   = 1'b0;
    clk_obs  = 1'b0;
    exp_freq = 4'd3;
    obs_lvl  = 1'b0;
    en_lvl   = 1'b1;
    m_cyc    = 0;
    m_ref    = 0;
    m_reset();
    @(posedge reference_clk);
    #1;
    chk("init_locked", {31'd0, locked}, 0);
    chk("init_hp", {27'd0, half_period}, 0);
    reference_rst_n = 1'b1;

    // Lock on divide-by-3
    cyc(1'b0, 1'b1); cyc(1'b0, 1'b1);
    repeat (4) half(3);
    chk("d3_not_yet", {31'd0, locked}, 0);
    half(3);
    chk("d3_locked", {31'd0, locked}, 1);
    chk("d3_hp", {27'd0, half_period}, 3);
    chk("d3_err", {31'd0, err}, 0);

    // Mismatch after lock, ERR holds while enabled
    half(4); half(3);
    chk("mm_err", {31'd0, err}, 1);
    chk("mm_locked", {31'd0, locked}, 0);
    chk("mm_hp", {27'd0, half_period}, 4);
    half(3); half(3);
    chk("mm_hold_locked", {31'd0, locked}, 0);
    cyc(obs_lvl, 1'b0);
    chk("mm_dis_err", {31'd0, err}, 1);

    // Re-lock with sticky err, then disable while LOCKED
    cyc(obs_lvl, 1'b1); cyc(obs_lvl, 1'b1);
    repeat (5) half(3);
    chk("relock", {31'd0, locked}, 1);
    cyc(obs_lvl, 1'b0);
    chk("dis_locked", {31'd0, locked}, 0);
    chk("dis_err_kept", {31'd0, err}, 1);
    cyc(obs_lvl, 1'b0);
    chk("dis_hp_clr", {27'd0, half_period}, 0);

    // Drive into ERR, then reset mid-ERR
    cyc(obs_lvl, 1'b1); cyc(obs_lvl, 1'b1);
    repeat (5) half(3);
    half(4); half(2);
    chk("err_again", {31'd0, err}, 1);
    do_reset();

    // Stall with exp_freq=2
    exp_freq = 4'd2;
    cyc(1'b0, 1'b1); cyc(1'b0, 1'b1);
    repeat (5) half(2);
    chk("st_locked", {31'd0, locked}, 1);
    cyc(obs_lvl, 1'b1); cyc(obs_lvl, 1'b1);
    chk("st_pre", {31'd0, err_stall}, 0);
    cyc(obs_lvl, 1'b1);
    chk("st_stall", {31'd0, err_stall}, 1);
    chk("st_locked_lo", {31'd0, locked}, 0);
    chk("st_err", {31'd0, err}, 0);
    do_reset();

    // Acquisition restart on an off-value half-period
    exp_freq = 4'd3;
    hs = '{3, 3, 5, 3, 3, 3, 3, 3};
    cyc(1'b0, 1'b1); cyc(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      half(hs[i]);
      if (i == 6) chk("acq_not_yet", {31'd0, locked}, 0);
    end
    chk("acq_locked", {31'd0, locked}, 1);
    chk("acq_err", {31'd0, err}, 0);
    do_reset();

    // Zero encodes 16
    exp_freq = 4'd0;
    cyc(1'b0, 1'b1); cyc(1'b0, 1'b1);
    repeat (5) half(16);
    chk("z16_hp", {27'd0, half_period}, 16);
    chk("z16_locked", {31'd0, locked}, 1);
    do_reset();
    exp_freq = 4'd0;
    cyc(1'b0, 1'b1); cyc(1'b0, 1'b1);
    repeat (8) half(15);
    chk("z15_locked", {31'd0, locked}, 0);
    chk("z15_hp", {27'd0, half_period}, 15);
    chk("z15_err", {31'd0, err}, 0);

    // Random half-period streams
    for (int t = 0; t < 6; t++) begin
      do_reset();
      exp_freq = 4'($urandom_range(0, 15));
      e = (exp_freq == '0) ? 16 : int'(exp_freq);
      cyc(1'b0, 1'b1); cyc(1'b0, 1'b1);
      for (int k = 0; k < 25; k++) begin
        r = int'($urandom_range(0, 11));
        h = e;
        if (r == 0) h = e + 1;
        else if (r == 1) h = (e > 1) ? e - 1 : e + 2;
        else if (r == 2) h = 2 * e + 1;
        if (r == 3) cyc(obs_lvl, 1'b0);
        half(h);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
